// File: rtl/alu_share_sequencer.sv
// alu_share_sequencer: round-robin arbiter that sequences one shared ALU through load, persist and capture
module alu_share_sequencer #(
  parameter int ALU_LAT = 2,
  parameter int OP_W = 6,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [OP_W-1:0] op0,
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   b0,
  input  logic            req1,
  input  logic [OP_W-1:0] op1,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   b1,
  output logic [1:0]      grant,
  output logic [1:0]      done,
  output logic [DW-1:0]   result,
  output logic [2:0]      alu_in_sel,
  output logic [DW-1:0]   alu_num1,
  output logic [DW-1:0]   alu_num2,
  output logic [OP_W-1:0] alu_out_sel,
  input  logic [DW-1:0]   alu_out,
  output logic [1:0]      state
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, EXEC = 2'b10, RESP = 2'b11} state_t;
  state_t st;
  logic last;
  logic owner;
  logic win;
  logic [3:0] cnt;
  assign win = (req0 && req1) ? !last : req1;
  assign state = st;
  // Arbitration and ALU sequencing; the ALU is reset alongside this block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      alu_in_sel <= 3'b001;
      grant <= 2'b00;
      done <= 2'b00;
      result <= '0;
      alu_num1 <= '0;
      alu_num2 <= '0;
      alu_out_sel <= '0;
      last <= 1'b1;
      owner <= 1'b0;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (req0 || req1) begin
            st <= LOAD;
            owner <= win;
            grant <= win ? 2'b10 : 2'b01;
            alu_in_sel <= 3'b010;
            alu_out_sel <= win ? op1 : op0;
            alu_num1 <= win ? a1 : a0;
            alu_num2 <= win ? b1 : b0;
          end else begin
            alu_in_sel <= 3'b000;
          end
        end
        LOAD: begin
          grant <= 2'b00;
          alu_in_sel <= 3'b100;
          cnt <= 4'(ALU_LAT - 1);
          st <= EXEC;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            result <= alu_out;
            done <= owner ? 2'b10 : 2'b01;
            alu_in_sel <= 3'b000;
            st <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          done <= 2'b00;
          last <= owner;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_sequencer.sv
// tb_alu_share_sequencer: table, hand-written and randomized checks of the shared-ALU sequencer
module tb_alu_share_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [5:0] op0 = '0, op1 = '0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0] grant, done, state;
  logic [7:0] result, alu_num1, alu_num2, alu_out;
  logic [2:0] alu_in_sel;
  logic [5:0] alu_out_sel;
  logic sreq = 1'b0;
  logic [5:0] sop = '0;
  logic [7:0] sa = '0, sb = '0;
  logic [1:0] g1, d1, st1, g15, d15, st15;
  logic [7:0] res1, n1a, n1b, ao1, res15, n15a, n15b, ao15;
  logic [2:0] is1, is15;
  logic [5:0] os1, os15;
  int passed = 0;
  int total = 0;
  bit last_w = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      6'd1: return x + y;
      6'd2: return x - y;
      6'd3: return x & y;
      6'd4: return x | y;
      6'd5: return x ^ y;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_f(alu_out_sel, alu_num1, alu_num2);
  assign ao1 = alu_f(os1, n1a, n1b);
  assign ao15 = alu_f(os15, n15a, n15b);

  alu_share_sequencer #(.ALU_LAT(2)) dut (
    .clk(clk), .reset(reset), .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .grant(grant), .done(done),
    .result(result), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out), .state(state));

  alu_share_sequencer #(.ALU_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req0(sreq), .op0(sop), .a0(sa), .b0(sb),
    .req1(1'b0), .op1(6'd0), .a1(8'd0), .b1(8'd0), .grant(g1), .done(d1),
    .result(res1), .alu_in_sel(is1), .alu_num1(n1a), .alu_num2(n1b),
    .alu_out_sel(os1), .alu_out(ao1), .state(st1));

  alu_share_sequencer #(.ALU_LAT(15)) u15 (
    .clk(clk), .reset(reset), .req0(sreq), .op0(sop), .a0(sa), .b0(sb),
    .req1(1'b0), .op1(6'd0), .a1(8'd0), .b1(8'd0), .grant(g15), .done(d15),
    .result(res15), .alu_in_sel(is15), .alu_num1(n15a), .alu_num2(n15b),
    .alu_out_sel(os15), .alu_out(ao15), .state(st15));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic run_txn(input bit r0, input bit r1, input logic [5:0] o0, input logic [5:0] o1,
                         input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                         input logic [7:0] y1, input logic [1:0] eg, input logic [7:0] er,
                         input string nm);
    int n;
    int pers;
    int bad;
    logic [7:0] en1, en2;
    req0 = r0; req1 = r1; op0 = o0; op1 = o1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    en1 = eg[1] ? x1 : x0;
    en2 = eg[1] ? y1 : y0;
    @(negedge clk);
    chk({nm, " grant"}, grant, eg);
    chk({nm, " load sel"}, alu_in_sel, 3'b010);
    req0 = 1'b0; req1 = 1'b0;
    n = 1; pers = 0; bad = 0;
    while (done == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
      if (alu_in_sel == 3'b100) begin
        pers++;
        if (alu_num1 !== en1 || alu_num2 !== en2) bad++;
      end
    end
    chk({nm, " latency"}, n, 4);
    chk({nm, " persist cycles"}, pers, 2);
    chk({nm, " operands stable"}, bad, 0);
    chk({nm, " done"}, done, eg);
    chk({nm, " result"}, result, er);
    chk({nm, " no grant with done"}, grant, 2'b00);
    @(negedge clk);
    chk({nm, " done cleared"}, {state, done}, 4'h0);
    last_w = eg[1];
  endtask

  typedef struct {
    bit r0, r1;
    logic [5:0] o0, o1;
    logic [7:0] x0, y0, x1, y1;
    logic [1:0] eg;
    logic [7:0] er;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, bad, t1, t15, p1, p15, both, r;
    logic [1:0] gq[$];
    logic [7:0] rq[$];
    logic [5:0] ro0, ro1;
    logic [7:0] rx0, ry0, rx1, ry1;
    bit w;
    vecs[0] = '{1, 1, 6'd1, 6'd1, 8'h00, 8'h01, 8'h10, 8'h05, 2'b01, 8'h01};
    vecs[1] = '{1, 1, 6'd1, 6'd1, 8'h00, 8'h01, 8'h10, 8'h05, 2'b10, 8'h15};
    vecs[2] = '{1, 1, 6'd1, 6'd1, 8'h00, 8'h01, 8'h10, 8'h05, 2'b01, 8'h01};
    vecs[3] = '{1, 0, 6'd1, 6'd0, 8'h57, 8'h1A, 8'h00, 8'h00, 2'b01, 8'h71};
    vecs[4] = '{0, 1, 6'd0, 6'd2, 8'h00, 8'h00, 8'h30, 8'h50, 2'b10, 8'hE0};
    vecs[5] = '{1, 1, 6'd3, 6'd4, 8'hF0, 8'h3C, 8'h11, 8'h22, 2'b01, 8'h30};
    #2 reset = 1'b1;
    #1;
    chk("rst in_sel", alu_in_sel, 3'b001);
    chk("rst ctl", {state, grant, done}, 0);
    chk("rst result", result, 0);
    chk("rst operands", {alu_num1, alu_num2, alu_out_sel}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {state, alu_in_sel, grant, done}, 0);
    end
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].r0, vecs[i].r1, vecs[i].o0, vecs[i].o1, vecs[i].x0, vecs[i].y0,
              vecs[i].x1, vecs[i].y1, vecs[i].eg, vecs[i].er, $sformatf("vec%0d", i));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1; req1 = 1; op0 = 6'd1; op1 = 6'd1;
    a0 = 8'h00; b0 = 8'h01; a1 = 8'h10; b1 = 8'h05;
    n = 0; both = 0;
    while (rq.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (grant != 2'b00) gq.push_back(grant);
      if (done != 2'b00) rq.push_back(result);
      if (grant != 2'b00 && done != 2'b00) both++;
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("hold grant count", gq.size(), 3);
    chk("hold grant0", gq.size() > 0 ? gq[0] : 2'b11, 2'b01);
    chk("hold grant1", gq.size() > 1 ? gq[1] : 2'b11, 2'b10);
    chk("hold grant2", gq.size() > 2 ? gq[2] : 2'b11, 2'b01);
    chk("hold result0", rq.size() > 0 ? rq[0] : 8'hFF, 8'h01);
    chk("hold result1", rq.size() > 1 ? rq[1] : 8'hFF, 8'h15);
    chk("hold grant/done overlap", both, 0);
    last_w = 1'b0;
    req0 = 1; op0 = 6'd1; a0 = 8'h22; b0 = 8'h11;
    @(negedge clk);
    chk("late grant0", grant, 2'b01);
    req0 = 0;
    @(negedge clk);
    chk("late exec", state, 2'b10);
    req1 = 1; op1 = 6'd2; a1 = 8'h09; b1 = 8'h04; a0 = 8'hFF;
    n = 0; bad = 0;
    while (done == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
      if (grant != 2'b00) bad++;
      if (alu_num1 !== 8'h22 || alu_num2 !== 8'h11) bad++;
    end
    chk("late no early grant", bad, 0);
    chk("late done0", done, 2'b01);
    chk("late result0", result, 8'h33);
    @(negedge clk);
    chk("late idle gap", {state, grant}, 4'h0);
    @(negedge clk);
    chk("late grant1", grant, 2'b10);
    chk("late operand1", alu_num1, 8'h09);
    req1 = 0;
    n = 0;
    while (done == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("late done1", done, 2'b10);
    chk("late result1", result, 8'h05);
    @(negedge clk);
    req0 = 1; op0 = 6'd1; a0 = 8'h10; b0 = 8'h20;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    chk("midrst exec", state, 2'b10);
    #2 reset = 1'b1;
    #1;
    chk("midrst in_sel", alu_in_sel, 3'b001);
    chk("midrst result", result, 0);
    chk("midrst ctl", {state, grant, done}, 0);
    chk("midrst operands", {alu_num1, alu_num2, alu_out_sel}, 0);
    @(negedge clk);
    chk("midrst no done", done, 2'b00);
    reset = 1'b0;
    last_w = 1'b1;
    run_txn(1, 0, 6'd1, 6'd0, 8'h40, 8'h02, 8'h00, 8'h00, 2'b01, 8'h42, "post reset");
    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(1, 3));
      ro0 = 6'($urandom_range(1, 5)); ro1 = 6'($urandom_range(1, 5));
      rx0 = 8'($urandom); ry0 = 8'($urandom); rx1 = 8'($urandom); ry1 = 8'($urandom);
      w = (r == 3) ? !last_w : (r == 2);
      run_txn(r[0], r[1], ro0, ro1, rx0, ry0, rx1, ry1, w ? 2'b10 : 2'b01,
              w ? alu_f(ro1, rx1, ry1) : alu_f(ro0, rx0, ry0), $sformatf("rand%0d", i));
    end
    sreq = 1; sop = 6'd1; sa = 8'h03; sb = 8'h04;
    n = 0; t1 = 0; t15 = 0; p1 = 0; p15 = 0;
    while ((t1 == 0 || t15 == 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) sreq = 0;
      if (is1 == 3'b100) p1++;
      if (is15 == 3'b100) p15++;
      if (t1 == 0 && d1 != 2'b00) t1 = n;
      if (t15 == 0 && d15 != 2'b00) t15 = n;
    end
    chk("lat1 done cycle", t1, 3);
    chk("lat15 done cycle", t15, 17);
    chk("lat1 persist", p1, 1);
    chk("lat15 persist", p15, 15);
    chk("lat1 result", res1, 8'h07);
    chk("lat15 result", res15, 8'h07);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
